// File: rtl/mdr_access_sequencer.sv
// Control FSM for the 16-bit MDR: sequences S-bus/M-bus loads, memory read/write
// handshakes, MDR bus drive during writes and the wait-state timeout abort.
module mdr_access_sequencer #(
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int WR_SETUP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic       s_load,
  input  logic       mem_ack,
  output logic       MMD,
  output logic       SMD,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mdr_drive,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [2:0] o_dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int SW = (WR_SETUP_CYCLES > 1) ? $clog2(WR_SETUP_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(WR_SETUP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SLOAD, S_RD_WAIT, S_RD_LATCH,
    S_WR_SETUP, S_WR_WAIT, S_WR_DONE, S_TMO
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_setup_cnt;
  logic          w_tmo_hit;

  // r_cnt counts completed wait cycles, so it equals TIMEOUT-1 in the last allowed one.
  assign w_tmo_hit   = (TIMEOUT_CYCLES > 0) && (r_cnt == TMO_LAST);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_setup_cnt <= '0;
      MMD         <= 1'b0;
      SMD         <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mdr_drive   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      MMD  <= 1'b0;
      SMD  <= 1'b0;
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (s_load) begin
            r_state <= S_SLOAD;
            SMD     <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b1;
            timeout <= 1'b0;
          end else if (rd_req) begin
            r_state <= S_RD_WAIT;
            r_cnt   <= '0;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            timeout <= 1'b0;
          end else if (wr_req) begin
            r_state     <= S_WR_SETUP;
            r_setup_cnt <= '0;
            mdr_drive   <= 1'b1;
            busy        <= 1'b1;
            timeout     <= 1'b0;
          end
        end
        S_SLOAD: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        S_RD_WAIT: begin
          if (mem_ack) begin
            r_state <= S_RD_LATCH;
            MMD     <= 1'b1;
            done    <= 1'b1;
          end else if (w_tmo_hit) begin
            r_state <= S_TMO;
            mem_req <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RD_LATCH: begin
          r_state <= S_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
        S_WR_SETUP: begin
          if (r_setup_cnt == SETUP_LAST) begin
            r_state <= S_WR_WAIT;
            r_cnt   <= '0;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
          end else begin
            r_setup_cnt <= r_setup_cnt + SW'(1);
          end
        end
        S_WR_WAIT: begin
          if (mem_ack || w_tmo_hit) begin
            r_state   <= mem_ack ? S_WR_DONE : S_TMO;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mdr_drive <= 1'b0;
            done      <= 1'b1;
            timeout   <= !mem_ack;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WR_DONE, S_TMO: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mdr_drive <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_access_sequencer.sv
// Bench for mdr_access_sequencer: each command's expected waveform is derived from
// its kind, setup length and ack position; a small MDR stub checks captured data.
module tb_mdr_access_sequencer;

  localparam int T = 16;
  localparam int S = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rd_req, wr_req, s_load, mem_ack;
  logic       MMD, SMD, mem_req, mem_we, mdr_drive, busy, done, timeout;
  logic [2:0] o_dbg_state;

  mdr_access_sequencer #(.TIMEOUT_CYCLES(T), .WR_SETUP_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .s_load(s_load),
    .mem_ack(mem_ack), .MMD(MMD), .SMD(SMD), .mem_req(mem_req), .mem_we(mem_we),
    .mdr_drive(mdr_drive), .busy(busy), .done(done), .timeout(timeout),
    .o_dbg_state(o_dbg_state)
  );

  // MDR datapath stub: mux feedback holds the value when neither select is high.
  logic [15:0] m_bus = 16'h0;
  logic [15:0] s_bus = 16'h0;
  logic [15:0] mdr   = 16'h0;
  always @(posedge clk) begin
    if (MMD)      mdr <= m_bus;
    else if (SMD) mdr <= s_bus;
  end

  wire [7:0] w_obs = {MMD, SMD, mem_req, mem_we, mdr_drive, busy, done, timeout};

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          sticky   = 1'b0;
  logic [15:0] exp_mdr  = 16'h0;

  task automatic check(input string tag, input int c, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s c=%0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask

  // Output bits {MMD,SMD,req,we,drive,busy,done,timeout} in cycle c after acceptance.
  // w = wait cycles spent, tmo = command aborted.
  function automatic logic [7:0] exp_at(input int kind, input int c, input int w,
                                        input bit tmo);
    logic [7:0] e;
    e = 8'b0;
    if (kind == 0) e = 8'b0100_0110;
    else if (kind == 1) begin
      if (c <= w) e = 8'b0010_0100;
      else        e = tmo ? 8'b0000_0111 : 8'b1010_0110;
    end else begin
      if (c <= S)          e = 8'b0000_1100;
      else if (c <= S + w) e = 8'b0011_1100;
      else                 e = tmo ? 8'b0000_0111 : 8'b0000_0110;
    end
    return e;
  endfunction

  // kind: 0 s_load, 1 read, 2 write. j: ack in wait cycle j (0 = never, >T = too late).
  // noise: stray requests while busy and stray acks outside wait cycles.
  // coin: lower-priority requests presented on the same edge.
  task automatic do_cmd(input int kind, input int j, input bit noise, input bit coin,
                        input logic [15:0] mval);
    int w, ws, L;
    bit tmo;
    tmo = (kind != 0) && (j == 0 || j > T);
    w   = (kind == 0) ? 0 : (tmo ? T : j);
    ws  = (kind == 2) ? S : 0;
    L   = (kind == 0) ? 1 : ws + w + 1;
    check("idle_before_cmd", 0, {8'b0, w_obs}, {15'b0, sticky});
    m_bus  = mval;
    s_bus  = 16'($urandom);
    s_load = (kind == 0);
    rd_req = (kind == 1) || (kind == 0 && coin);
    wr_req = (kind == 2) || (kind < 2 && coin);
    @(posedge clk); #1;
    for (int c = 1; c <= L; c++) begin
      check($sformatf("out_k%0d", kind), c, {8'b0, w_obs}, {8'b0, exp_at(kind, c, w, tmo)});
      mem_ack = (j > 0) && (c == ws + j);
      s_load = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
      if (noise) begin
        if (c <= ws || c > ws + w) mem_ack = mem_ack | 1'($urandom_range(0, 1));
        s_load = 1'($urandom_range(0, 1));
        rd_req = 1'($urandom_range(0, 1));
        wr_req = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    s_load = 1'b0; rd_req = 1'b0; wr_req = 1'b0; mem_ack = 1'b0;
    if (kind == 0) exp_mdr = s_bus;
    else if (kind == 1 && !tmo) exp_mdr = mval;
    sticky = tmo;
    check("mdr", L, mdr, exp_mdr);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle", i, {8'b0, w_obs}, {15'b0, sticky});
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; s_load = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 0, {8'b0, w_obs}, 16'h0);
    check("reset_state", 0, {13'b0, o_dbg_state}, 16'h0);
    rst_n = 1'b1;
    idle_cycles(3);

    do_cmd(1, 3, 1'b0, 1'b0, 16'hA5C3);    // read, ack in cycle N+3
    do_cmd(2, 1, 1'b0, 1'b0, 16'h0);       // write, ack in first wait cycle
    do_cmd(0, 0, 1'b0, 1'b1, 16'h0);       // s_load+rd_req+wr_req together
    do_cmd(1, 0, 1'b0, 1'b0, 16'h1111);    // read timeout
    idle_cycles(4);
    do_cmd(2, 2, 1'b0, 1'b0, 16'h0);       // timeout cleared on next accepted cmd
    do_cmd(1, T, 1'b0, 1'b0, 16'h5A5A);    // ack in last allowed cycle
    do_cmd(2, T, 1'b0, 1'b0, 16'h0);
    do_cmd(2, 0, 1'b0, 1'b0, 16'h0);       // write timeout
    do_cmd(1, T + 1, 1'b0, 1'b0, 16'h2222); // ack arrives one cycle late
    do_cmd(1, 5, 1'b1, 1'b0, 16'h3C3C);    // stray requests/acks while busy
    idle_cycles(3);

    // Asynchronous reset in the middle of WR_WAIT, checked before any clock edge.
    check("idle_before_wr", 0, {8'b0, w_obs}, {15'b0, sticky});
    wr_req = 1'b1;
    @(posedge clk); #1;
    wr_req = 1'b0;
    check("wr_setup", 1, {8'b0, w_obs}, 16'h000C);
    @(posedge clk); #1;
    check("wr_wait", 2, {8'b0, w_obs}, 16'h003C);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 0, {8'b0, w_obs}, 16'h0);
    check("async_reset_state", 0, {13'b0, o_dbg_state}, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sticky = 1'b0;
    do_cmd(1, 3, 1'b0, 1'b0, 16'hA5C3);

    for (int n = 0; n < 40; n++) begin
      int kind, j;
      kind = $urandom_range(0, 2);
      j = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1) * (T + 1) : $urandom_range(1, T);
      do_cmd(kind, j, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
